move_parser: RTL and testbench

//  Byte-stream front end for the dial-rotation stage: turns ASCII move lines ("L68\n", "R14\n")

---
 rtl/move_pkg.sv | 15 +
 rtl/dec_accumulator.sv | 12 +
 rtl/move_parser.sv | 123 ++++++++++++
 tb/tb_move_parser.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/move_pkg.sv
// move_pkg: parser states, ASCII codes and the move record shared with the dial stage
package move_pkg;
  typedef enum logic [1:0] {IDLE, DIGITS, SKIP, EMIT} parse_state_t;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam int MOVE_DIST_W = 16;
  typedef struct packed {
    logic                   dir;
    logic [MOVE_DIST_W-1:0] distance;
  } move_t;
endpackage

// File: rtl/dec_accumulator.sv
// dec_accumulator: saturating acc*10+digit, computed four bits wider than the result
module dec_accumulator #(
  parameter int DIST_W = 16
) (
  input  logic [DIST_W-1:0] acc_i,
  input  logic [3:0]        digit_i,
  output logic [DIST_W-1:0] acc_o
);
  logic [DIST_W+3:0] wide;
  assign wide  = ({4'b0, acc_i} << 3) + ({4'b0, acc_i} << 1) + {{DIST_W{1'b0}}, digit_i};
  assign acc_o = |wide[DIST_W+3:DIST_W] ? '1 : wide[DIST_W-1:0];
endmodule

// File: rtl/move_parser.sv
// move_parser: ASCII move lines to {direction, distance} requests over valid/ready
module move_parser
  import move_pkg::*;
#(
  parameter int DIST_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              move_valid,
  output logic              move_direction,
  output logic [DIST_W-1:0] move_distance,
  input  logic              move_ready,
`ifdef MOVE_PARSER_ERRCNT_EN
  output logic [15:0]       err_count,
`endif
  output logic              done
);
  parse_state_t state_q, state_d;
  logic dir_q, dir_d, have_q, have_d, last_q, last_d, done_q, done_d, err;
  logic [DIST_W-1:0] acc_q, acc_d, acc_next;
  logic fire, is_dig, is_lf, is_cr, is_dir;

  dec_accumulator #(.DIST_W(DIST_W)) u_acc (
    .acc_i  (acc_q),
    .digit_i(in_data[3:0]),
    .acc_o  (acc_next)
  );

  assign in_ready       = (state_q != EMIT) && !done_q;
  assign move_valid     = state_q == EMIT;
  assign move_direction = dir_q;
  assign move_distance  = acc_q;
  assign done           = done_q;
  assign fire   = in_valid && in_ready;
  assign is_dig = in_data >= CH_0 && in_data <= CH_9;
  assign is_lf  = in_data == CH_LF;
  assign is_cr  = in_data == CH_CR;
  assign is_dir = in_data == CH_L || in_data == CH_R;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    acc_d   = acc_q;
    have_d  = have_q;
    last_d  = last_q;
    done_d  = done_q;
    err     = 1'b0;
    if (fire) begin
      case (state_q)
        IDLE: begin
          if (is_dir) begin
            dir_d   = in_data == CH_R;
            acc_d   = '0;
            have_d  = 1'b0;
            state_d = DIGITS;
          end else if (!is_lf && !is_cr) begin
            state_d = SKIP;
            err     = 1'b1;
          end
        end
        DIGITS: begin
          if (is_dig) begin
            acc_d  = acc_next;
            have_d = 1'b1;
          end else if (is_lf) begin
            state_d = have_q ? EMIT : IDLE;
            err     = !have_q;
          end else if (!is_cr) begin
            state_d = SKIP;
            err     = 1'b1;
          end
        end
        SKIP: state_d = is_lf ? IDLE : SKIP;
        default: ;
      endcase
      if (in_last) begin
        if (state_d == DIGITS) begin
          state_d = have_d ? EMIT : IDLE;
          err     = !have_d;
        end
        last_d = state_d == EMIT;
        done_d = state_d != EMIT;
      end
    end else if (state_q == EMIT && move_ready) begin
      state_d = IDLE;
      done_d  = last_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      acc_q   <= '0;
      have_q  <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      acc_q   <= acc_d;
      have_q  <= have_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

`ifdef MOVE_PARSER_ERRCNT_EN
  logic [15:0] err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else if (err && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
  end
  assign err_count = err_q;
`else
  logic err_unused;
  assign err_unused = err;
`endif
endmodule

// File: tb/tb_move_parser.sv
// tb_move_parser: directed and random byte streams checked against a line-level reference model
module tb_move_parser;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, move_ready = 1;
  logic [7:0] in_data = 0;
  logic in_ready, move_valid, move_direction, done;
  logic [15:0] move_distance;
`ifdef MOVE_PARSER_ERRCNT_EN
  logic [15:0] err_count;
`endif

  move_parser dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .move_valid(move_valid), .move_direction(move_direction),
    .move_distance(move_distance), .move_ready(move_ready),
`ifdef MOVE_PARSER_ERRCNT_EN
    .err_count(err_count),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, exp_err = 0, stall_left = 0;
  bit rnd_ready = 0, gaps = 0;
  bit [16:0] exp_q[$];

  task automatic chk(string tag, longint got, longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference: one line at a time, carriage returns dropped, value clamped to 16 bits
  task automatic eval_line(string ln);
    longint v = 0;
    if (ln.len() == 0) return;
    if ((ln[0] != "L" && ln[0] != "R") || ln.len() == 1) begin exp_err++; return; end
    for (int i = 1; i < ln.len(); i++) begin
      if (ln[i] < "0" || ln[i] > "9") begin exp_err++; return; end
      v = v * 10 + longint'(ln[i] - "0");
      if (v > 65535) v = 65535;
    end
    exp_q.push_back({ln[0] == "R", 16'(v)});
  endtask

  task automatic model(string s);
    string ln = "";
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s[i] == "\n") begin eval_line(ln); ln = ""; end
      else if (s[i] != "\r") ln = {ln, s.substr(i, i)};
    end
  endtask

  task automatic send_byte(byte b, bit l);
    bit acc;
    int t = 0;
    in_valid = 1; in_data = b; in_last = l;
    do begin acc = in_ready; @(posedge clk); @(negedge clk); t++; end while (!acc && t < 200);
    if (!acc) chk("in_ready_timeout", 0, 1);
    in_valid = 0; in_last = 0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic feed(string s, bit last);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], last && i == s.len() - 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; in_valid = 0; in_last = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_move_valid", move_valid, 0);
    chk("rst_dir", move_direction, 0);
    chk("rst_dist", move_distance, 0);
    chk("rst_done", done, 0);
    exp_q.delete(); exp_err = 0; stall_left = 0;
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || move_valid) && t < 400) begin @(negedge clk); t++; end
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_valid", move_valid, 0);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 400) begin @(negedge clk); t++; end
    chk("done", done, 1);
    chk("done_in_ready", in_ready, 0);
    chk("done_pending", exp_q.size(), 0);
  endtask

  task automatic chk_err();
`ifdef MOVE_PARSER_ERRCNT_EN
    chk("err_count", err_count, exp_err);
`endif
  endtask

  function automatic string rand_line();
    int k = $urandom_range(0, 9);
    string s = "";
    if (k <= 5 || k == 6 || k == 8) begin
      s = k == 6 ? "X" : ($urandom_range(0, 1) ? "R" : "L");
      for (int i = 0, n = $urandom_range(1, 7); i < n; i++) begin
        s = $sformatf("%s%c", s, 8'(48 + $urandom_range(0, 9)));
        if ($urandom_range(0, 7) == 0) s = {s, "\r"};
      end
      if (k == 8) s = {s, "a2"};
    end else if (k == 7) s = $urandom_range(0, 1) ? "L" : "R\r";
    else s = $urandom_range(0, 1) ? "" : "\r";
    return s;
  endfunction

  // downstream side: stability while stalled, ordered scoreboard on each handshake
  initial begin
    bit pv = 0, pr = 0, pd = 0;
    bit [15:0] pdist = 0;
    bit [16:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin pv = 0; continue; end
      if (pv && !pr) begin
        chk("stall_valid", move_valid, 1);
        chk("stall_dir", move_direction, pd);
        chk("stall_dist", move_distance, pdist);
      end
      if (move_valid) chk("emit_in_ready", in_ready, 0);
      if (move_valid && stall_left > 0) begin move_ready = 0; stall_left--; end
      else move_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (move_valid && move_ready) begin
        if (exp_q.size() == 0) chk("spurious_move", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("move_dir", move_direction, e[16]);
          chk("move_dist", move_distance, e[15:0]);
        end
      end
      pv = move_valid; pr = move_ready; pd = move_direction; pdist = move_distance;
    end
  end

  initial begin
    string f;
    do_reset();
    // 1: latency of exactly one cycle after the newline is accepted
    model("L68\n");
    feed("L68", 0);
    chk("t1_no_early_valid", move_valid, 0);
    send_byte("\n", 0);
    chk("t1_valid_next_cycle", move_valid, 1);
    wait_drain();
    // 2: downstream stall
    do_reset();
    model("R14\nL5\n");
    stall_left = 5;
    feed("R14\nL5\n", 0);
    wait_drain();
    // 3: saturation and leading zeros
    do_reset();
    model("R70000\nR065535\n");
    feed("R70000\nR065535\n", 0);
    wait_drain();
    chk("t3_err", exp_err, 0);
    chk_err();
    // 4: malformed lines
    do_reset();
    model("X12\nL\nR3\n");
    feed("X12\nL\nR3\n", 0);
    wait_drain();
    chk("t4_model_err", exp_err, 2);
    chk_err();
    // 5: blank lines, CRLF and in_last termination
    do_reset();
    model("\r\n\nL7\r\nR9");
    feed("\r\n\nL7\r\nR", 0);
    chk("t5_done_early", done, 0);
    send_byte("9", 1);
    wait_done();
    chk_err();
    // 6: reset mid-line
    do_reset();
    feed("R1", 0);
    do_reset();
    model("L1\n");
    feed("L1\n", 0);
    wait_drain();
    chk_err();
    // random files with random gaps and backpressure
    rnd_ready = 1; gaps = 1;
    for (int it = 0; it < 30; it++) begin
      do_reset();
      f = "";
      for (int l = 0, n = $urandom_range(1, 6); l < n; l++) f = {f, rand_line(), "\n"};
      if ($urandom_range(0, 1)) f = {f, rand_line()};
      if (f[f.len() - 1] == "\n" && $urandom_range(0, 1)) f = f.substr(0, f.len() - 2);
      if (f.len() == 0) f = "L1";
      model(f);
      feed(f, 1);
      wait_done();
      chk_err();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
